// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder. Operands are cut into STAGES chunks. Each stage adds
// one chunk. Skew registers carry the unused operand chunks forward, and deskew registers do the same for finished sum chunks.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  // Bit offset of pipeline level k inside the packed skew buses. Level k holds the
  // operand bits above chunk k, so its width shrinks by CHUNK at every level.
  function automatic int sk_off(input int k);
    int acc;
    acc = 0;
    for (int j = 0; j < k; j++) acc += WIDTH - (j + 1) * CHUNK;
    return acc;
  endfunction

  // Bit offset of level k inside the deskew bus. Level k holds sum chunks 0..k.
  function automatic int ds_off(input int k);
    return CHUNK * k * (k + 1) / 2;
  endfunction

  // Kogge-Stone prefix over one chunk. Returns {carry_out, sum}.
  function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    logic [CHUNK-1:0] p, g, gp, pp;
    logic [CHUNK:0]   c;
    p  = a ^ b;
    g  = a & b;
    gp = g;
    pp = p;
    for (int d = 1; d < CHUNK; d = d * 2) begin
      for (int i = CHUNK - 1; i >= d; i--) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) c[i+1] = gp[i] | (pp[i] & cin);
    return {c[CHUNK], p ^ c[CHUNK-1:0]};
  endfunction

  localparam int LVLS    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int SK_BITS = (STAGES > 1) ? sk_off(STAGES - 1) : 1;
  localparam int DS_BITS = (STAGES > 1) ? ds_off(STAGES - 1) : 1;

  logic [SK_BITS-1:0] a_sk, b_sk;
  logic [DS_BITS-1:0] ds;
  logic [LVLS-1:0]    c_sk;

  logic [STAGES-1:0]  vld_q, vld_d;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q, ovf_q;
  logic               stall;

  // Handshake: a beat moves on either side only when valid && ready are both high in the
  // same cycle. in_ready depends only on out_valid/out_ready, so no input-to-ready path exists.
  assign stall     = vld_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      vld_q <= '0;
    else if (!stall) vld_q <= vld_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_c, b_c;
    logic             c_in, en;
    logic [CHUNK:0]   res;

    if (k == 0) begin : g_from_in
      assign a_c  = in_1[CHUNK-1:0];
      assign b_c  = in_2[CHUNK-1:0];
      assign c_in = carry_in;
      assign en   = in_valid & ~stall;
    end else begin : g_from_pipe
      localparam int SRC_SK = sk_off(k - 1);
      assign a_c  = a_sk[SRC_SK +: CHUNK];
      assign b_c  = b_sk[SRC_SK +: CHUNK];
      assign c_in = c_sk[k-1];
      assign en   = vld_q[k-1] & ~stall;
    end

    assign res = cla_chunk(a_c, b_c, c_in);

    if (k < STAGES - 1) begin : g_skew
      localparam int HI_W   = WIDTH - (k + 1) * CHUNK;
      localparam int LO_W   = (k + 1) * CHUNK;
      localparam int DST_SK = sk_off(k);
      localparam int DST_DS = ds_off(k);
      logic [HI_W-1:0] a_hi_d, b_hi_d, a_hi_q, b_hi_q;
      logic [LO_W-1:0] lo_d, lo_q;
      logic            c_q;

      if (k == 0) begin : g_first
        assign a_hi_d = in_1[WIDTH-1:CHUNK];
        assign b_hi_d = in_2[WIDTH-1:CHUNK];
        assign lo_d   = res[CHUNK-1:0];
      end else begin : g_mid
        localparam int SRC_SK = sk_off(k - 1);
        localparam int SRC_DS = ds_off(k - 1);
        assign a_hi_d = a_sk[SRC_SK + CHUNK +: HI_W];
        assign b_hi_d = b_sk[SRC_SK + CHUNK +: HI_W];
        assign lo_d   = {res[CHUNK-1:0], ds[SRC_DS +: k * CHUNK]};
      end

      // Data registers load only with a valid beat, so bubbles leave them untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
          lo_q   <= '0;
          c_q    <= 1'b0;
        end else if (en) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
          lo_q   <= lo_d;
          c_q    <= res[CHUNK];
        end
      end

      assign a_sk[DST_SK +: HI_W] = a_hi_q;
      assign b_sk[DST_SK +: HI_W] = b_hi_q;
      assign ds[DST_DS +: LO_W]   = lo_q;
      assign c_sk[k]              = c_q;
    end else begin : g_last
      logic [WIDTH-1:0] sum_d;
      logic             msb_c;

      if (k == 0) begin : g_single
        assign sum_d = res[CHUNK-1:0];
      end else begin : g_join
        localparam int SRC_DS = ds_off(k - 1);
        assign sum_d = {res[CHUNK-1:0], ds[SRC_DS +: k * CHUNK]};
      end

      // Carry into the MSB is recovered from the MSB sum bit itself.
      assign msb_c = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ res[CHUNK-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (en) begin
          sum_q  <= sum_d;
          cout_q <= res[CHUNK];
          ovf_q  <= msb_c ^ res[CHUNK];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: three configurations (32/4, 32/1, 64/8) share one
// stimulus stream; each has its own expected queue fed by an arithmetic model.
module tb_pipelined_cla_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_1, in_2;
  logic        carry_in;
  logic        out_ready;

  logic [2:0]  ir, ov;
  logic [31:0] sum0, sum1;
  logic [63:0] sum2;
  logic [2:0]  cout, ovf;
  logic [65:0] act [3];

  int vectors;
  int miscompares;
  logic [65:0] exp_q [3][$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  vec_t tab [8];

  pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_1(in_1[31:0]), .in_2(in_2[31:0]), .carry_in(carry_in),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(sum0),
    .carry_out(cout[0]), .overflow(ovf[0])
  );

  pipelined_cla_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_1(in_1[31:0]), .in_2(in_2[31:0]), .carry_in(carry_in),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(sum1),
    .carry_out(cout[1]), .overflow(ovf[1])
  );

  pipelined_cla_adder #(.WIDTH(64), .STAGES(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_1(in_1), .in_2(in_2), .carry_in(carry_in),
    .out_valid(ov[2]), .out_ready(out_ready), .sum(sum2),
    .carry_out(cout[2]), .overflow(ovf[2])
  );

  assign act[0] = {ovf[0], cout[0], 32'h0, sum0};
  assign act[1] = {ovf[1], cout[1], 32'h0, sum1};
  assign act[2] = {ovf[2], cout[2], sum2};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int dw(input int d);
    return (d == 2) ? 64 : 32;
  endfunction

  // {overflow, carry_out, sum} from plain wide arithmetic and the signed-overflow rule.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input int w);
    logic [63:0] mask, am, bm, s;
    logic [64:0] full;
    logic        co, v;
    mask = (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
    am   = a & mask;
    bm   = b & mask;
    full = {1'b0, am} + {1'b0, bm} + {64'h0, cin};
    co   = full[w];
    s    = full[63:0] & mask;
    v    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {v, co, s};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [65:0] got, input logic [65:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && out_ready) begin
          if (exp_q[d].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d unexpected beat: got %h expected none", d, act[d]);
          end else begin
            check($sformatf("dut%0d out", d), act[d], exp_q[d].pop_front());
          end
        end
        if (in_valid && ir[d]) exp_q[d].push_back(model(in_1, in_2, carry_in, dw(d)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    in_1     = {$urandom, $urandom};
    in_2     = {$urandom, $urandom};
    carry_in = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) in_1 = {64{1'b1}};
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0) break;
    end
    for (int d = 0; d < 3; d++)
      check($sformatf("%s dut%0d pending", tag, d), 66'(exp_q[d].size()), 66'd0);
  endtask

  task automatic idle_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s dut%0d out_valid", tag, d), 66'(ov[d]), 66'd0);
      check($sformatf("%s dut%0d outputs", tag, d), act[d], 66'd0);
      check($sformatf("%s dut%0d in_ready", tag, d), 66'(ir[d]), 66'd1);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat [3];
    int first, last, n;
    bit got;

    vectors     = 0;
    miscompares = 0;
    tab[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tab[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tab[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tab[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tab[4] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tab[5] = '{32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, 1'b0};
    tab[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    tab[7] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_1      = '0;
    in_2      = '0;
    carry_in  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    idle_state("reset");

    // latency of a single beat
    step();
    in_valid = 1'b1;
    rand_beat();
    lat = '{0, 0, 0};
    for (int c = 1; c <= 20; c++) begin
      step();
      in_valid = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (lat[d] == 0 && ov[d]) lat[d] = c;
    end
    check("latency dut0", 66'(lat[0]), 66'd4);
    check("latency dut1", 66'(lat[1]), 66'd1);
    check("latency dut2", 66'(lat[2]), 66'd8);
    drain("latency");

    // directed corner table on the 32/4 configuration
    for (int t = 0; t < 8; t++) begin
      step();
      in_valid = 1'b1;
      in_1     = {32'h0, tab[t].a};
      in_2     = {32'h0, tab[t].b};
      carry_in = tab[t].cin;
      step();
      in_valid = 1'b0;
      got      = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (ov[0]) got = 1'b1;
        else step();
      end
      if (!got) begin
        vectors++;
        miscompares++;
        $display("FAIL table %0d timeout: got no out_valid expected result within 20 cycles", t);
      end else begin
        check($sformatf("table %0d", t), {32'h0, ovf[0], cout[0], sum0},
              {32'h0, tab[t].ov, tab[t].co, tab[t].s});
      end
    end
    drain("table");

    // 100 back-to-back beats, no gaps on the output
    first = -1;
    last  = -1;
    n     = 0;
    for (int c = 0; c < 130; c++) begin
      step();
      if (c < 100) begin
        in_valid = 1'b1;
        rand_beat();
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (ov[0]) begin
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    check("stream count", 66'(n), 66'd100);
    check("stream gapless", 66'(last - first + 1), 66'd100);
    drain("stream");

    // full pipeline, then three stalled cycles
    for (int c = 0; c < 6; c++) begin
      step();
      in_valid = 1'b1;
      rand_beat();
    end
    step();
    out_ready = 1'b0;
    rand_beat();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall %0d in_ready", c), 66'(ir[0]), 66'd0);
      if (exp_q[0].size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stall %0d hold: got empty queue expected a pending beat", c);
      end else begin
        check($sformatf("stall %0d hold", c), act[0], exp_q[0][0]);
      end
      if (c < 2) begin
        step();
        rand_beat();
      end
    end
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_beat();
      step();
    end
    drain("backpressure");

    // random valid / ready toggling
    for (int c = 0; c < 300; c++) begin
      step();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
    end
    drain("random");

    // reset with beats in flight
    for (int c = 0; c < 3; c++) begin
      step();
      in_valid = 1'b1;
      rand_beat();
    end
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    #1;
    idle_state("midreset");
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      in_valid = 1'b1;
      rand_beat();
    end
    drain("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
